// File: rtl/keypress_sequencer_pkg.sv
// Shared constants and types for the keypress sequencer.
//   - PS/2 set-2 scancodes for the game keys and the break/extended prefixes
//   - 3-bit key codes consumed by the Simon game FSM
//   - seq_state_t: prefix-tracking FSM states
//   - decode_key(): scancode byte -> key code
// Optional feature macro: KEYSEQ_RELEASE_EVT_EN (widens FIFO entries by a release flag).
package simon_pkg;

  localparam logic [7:0] SC_Q     = 8'h15;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [2:0] KEY_GREEN  = 3'd0;
  localparam logic [2:0] KEY_RED    = 3'd1;
  localparam logic [2:0] KEY_YELLOW = 3'd2;
  localparam logic [2:0] KEY_BLUE   = 3'd3;
  localparam logic [2:0] KEY_ENTER  = 3'd4;
  localparam logic [2:0] KEY_NONE   = 3'd5;

  localparam int unsigned NumKeys = 5;

`ifdef KEYSEQ_RELEASE_EVT_EN
  localparam int unsigned EvtWidth = 4;  // {release, code}
`else
  localparam int unsigned EvtWidth = 3;  // code
`endif

  typedef enum logic [1:0] {
    StIdle,
    StBrk,
    StExt,
    StExtBrk
  } seq_state_t;

  function automatic logic [2:0] decode_key(input logic [7:0] sc);
    logic [2:0] code;
    case (sc)
      SC_Q:     code = KEY_GREEN;
      SC_W:     code = KEY_RED;
      SC_A:     code = KEY_YELLOW;
      SC_S:     code = KEY_BLUE;
      SC_ENTER: code = KEY_ENTER;
      default:  code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypress_sequencer_if.sv
// Bundle between the scancode source / game FSM and the keypress sequencer.
//   scan_valid/scan_byte : scancode strobe and byte (source -> sequencer)
//   flush                : synchronous clear request (source -> sequencer)
//   evt_valid/evt_ready  : event handshake, evt_code is the head key code
//   ovf_cnt, busy        : status (sequencer -> consumer)
//   evt_release          : present only with KEYSEQ_RELEASE_EVT_EN defined
// modport master: environment side; modport slave: sequencer side.
interface keypress_sequencer_if;
  logic       scan_valid;
  logic [7:0] scan_byte;
  logic       flush;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_code;
  logic [7:0] ovf_cnt;
  logic       busy;
`ifdef KEYSEQ_RELEASE_EVT_EN
  logic       evt_release;

  modport master (
    output scan_valid, scan_byte, flush, evt_ready,
    input  evt_valid, evt_code, ovf_cnt, busy, evt_release
  );
  modport slave (
    input  scan_valid, scan_byte, flush, evt_ready,
    output evt_valid, evt_code, ovf_cnt, busy, evt_release
  );
`else
  modport master (
    output scan_valid, scan_byte, flush, evt_ready,
    input  evt_valid, evt_code, ovf_cnt, busy
  );
  modport slave (
    input  scan_valid, scan_byte, flush, evt_ready,
    output evt_valid, evt_code, ovf_cnt, busy
  );
`endif
endinterface

// File: rtl/keypress_sequencer_key_event_fifo.sv
// Small synchronous FIFO for key events.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : synchronous empty (wins over push/pop)
//   push_i     : write data_i; accepted when not full, or when full with pop_i
//   pop_i      : drop head entry when non-empty
//   data_o     : head entry, forced to zero when empty
//   full_o, empty_o : status from pointers with an extra wrap bit
module key_event_fifo #(
  parameter int unsigned Width = 3,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: the output is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wptr_q[AddrW-1:0]] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rptr_q[AddrW-1:0]];

endmodule

// File: rtl/keypress_sequencer.sv
// Keypress sequencer: turns the raw PS/2 scancode stream into one press event per
// physical keystroke for the Simon game FSM.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : scan_valid/scan_byte in, flush in, evt_valid/evt_ready/evt_code
//                event handshake, ovf_cnt (saturating drop count), busy (prefix pending)
// Parameters: DEPTH (event FIFO entries, power of 2, >= 2), TIMEOUT_CYC (idle cycles
// in a prefix state before it is abandoned).
// Optional feature macro: KEYSEQ_RELEASE_EVT_EN -- breaks of held keys also queue
// events, flagged on bus.evt_release.
module keypress_sequencer
  import simon_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  keypress_sequencer_if.slave  bus
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  seq_state_t          state_q, state_d;
  logic [NumKeys-1:0]  held_q, held_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [7:0]          ovf_q, ovf_d;

  logic [2:0]          key;
  logic                push;
  logic                push_rel;
  logic [2:0]          push_code;
  logic [EvtWidth-1:0] push_data;
  logic [EvtWidth-1:0] head;
  logic                fifo_full, fifo_empty;
  logic                pop;

  assign key = decode_key(bus.scan_byte);
  assign pop = !fifo_empty && bus.evt_ready;

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_rel  = 1'b0;
    push_code = key;
    if (bus.flush) begin
      // Flush also swallows a coincident scancode byte.
      state_d = StIdle;
      held_d  = '0;
      cnt_d   = '0;
    end else if (bus.scan_valid) begin
      cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (bus.scan_byte == SC_BREAK) begin
            state_d = StBrk;
          end else if (bus.scan_byte == SC_EXT) begin
            state_d = StExt;
          end else if (key != KEY_NONE && !held_q[key]) begin
            // Held keys are typematic repeats and produce nothing.
            held_d[key] = 1'b1;
            push        = 1'b1;
          end
        end
        StBrk: begin
          state_d = StIdle;
          if (key != KEY_NONE) begin
            held_d[key] = 1'b0;
`ifdef KEYSEQ_RELEASE_EVT_EN
            push     = held_q[key];
            push_rel = 1'b1;
`endif
          end
        end
        StExt: begin
          state_d = StIdle;
          if (bus.scan_byte == SC_BREAK) begin
            state_d = StExtBrk;
          end else if (bus.scan_byte == SC_ENTER && !held_q[KEY_ENTER]) begin
            // Keypad enter shares the key code with main enter.
            held_d[KEY_ENTER] = 1'b1;
            push              = 1'b1;
            push_code         = KEY_ENTER;
          end
        end
        StExtBrk: begin
          state_d = StIdle;
          if (bus.scan_byte == SC_ENTER) begin
            held_d[KEY_ENTER] = 1'b0;
            push_code         = KEY_ENTER;
`ifdef KEYSEQ_RELEASE_EVT_EN
            push     = held_q[KEY_ENTER];
            push_rel = 1'b1;
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      // A stalled prefix (e.g. a lost byte) must not capture the next keystroke.
      if (cnt_q == CntLast) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

`ifdef KEYSEQ_RELEASE_EVT_EN
  assign push_data = {push_rel, push_code};
`else
  assign push_data = push_code;
`endif

  // A push into a full FIFO without a simultaneous pop is lost and counted.
  always_comb begin
    ovf_d = ovf_q;
    if (push && fifo_full && !pop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      held_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  key_event_fifo #(
    .Width (EvtWidth),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (bus.flush),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.evt_valid = !fifo_empty;
  assign bus.evt_code  = head[2:0];
  assign bus.ovf_cnt   = ovf_q;
  assign bus.busy      = (state_q != StIdle);
`ifdef KEYSEQ_RELEASE_EVT_EN
  assign bus.evt_release = head[3];
`endif

  // Keep push_rel referenced in builds without release events.
  logic unused_rel;
  assign unused_rel = push_rel;

endmodule
